// File: rtl/dual_port_ram_pkg.sv
// Shared constants, clear-FSM state encoding and the byte-merge helper
// used by the parametrised dual-port RAM.
package dual_port_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Merge helper works on a fixed maximum width; callers size-cast in and out.
    localparam int MERGE_W  = 256;
    localparam int MERGE_BE = MERGE_W / 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_CLEAR = CLEAR;

    function automatic logic [MERGE_W-1:0] merge(
        input logic [MERGE_W-1:0]  old_w,
        input logic [MERGE_W-1:0]  new_w,
        input logic [MERGE_BE-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_BE; i++) begin
            if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dual_port_ram_clr_fsm.sv
// Clear sequencer: after reset or on request, walks every word once and
// drives a zero-write strobe/address that the top muxes onto port A.
module dual_port_ram_clr_fsm
    import dual_port_ram_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic [0:0]        state,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                    end
                end
                ST_CLEAR: begin
                    // clr_req is deliberately not looked at here
                    if (ptr == LAST) state <= ST_IDLE;
                    ptr <= ptr + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state == ST_CLEAR);
    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = ptr;

endmodule

// File: rtl/dual_port_ram_param.sv
// True dual-port RAM with byte enables, registered reads with valid flags,
// selectable read-during-write, collision arbitration and hardware clear.
module dual_port_ram_param
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int DEPTH    = 2**ADDR_W,
    parameter int RDW_MODE = RDW_READ_FIRST
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_req,
    output logic                busy,
    input  logic                en_a,
    input  logic                rwe_a,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [DATA_W-1:0]   data_a,
    output logic [DATA_W-1:0]   data_outa,
    output logic                valid_a,
    input  logic                en_b,
    input  logic                rwe_b,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic [DATA_W-1:0]   data_b,
    output logic [DATA_W-1:0]   data_outb,
    output logic                valid_b,
    output logic                collision
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        clr_state;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    dual_port_ram_clr_fsm #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .state    (clr_state),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic              acc_a, acc_b, in_a, in_b, wr_a, wr_b;
    logic              same, coll, both_wr;
    logic [DATA_W-1:0] old_a, old_b, new_a, new_b, base_b;
    logic [BE_W-1:0]   be_b_eff;
    logic              pa_we;
    logic [ADDR_W-1:0] pa_addr;
    logic [DATA_W-1:0] pa_data;

    always_comb begin
        acc_a   = en_a && (clr_state == ST_IDLE);
        acc_b   = en_b && (clr_state == ST_IDLE);
        in_a    = {1'b0, addr_a} < (ADDR_W+1)'(DEPTH);
        in_b    = {1'b0, addr_b} < (ADDR_W+1)'(DEPTH);
        wr_a    = acc_a && rwe_a && in_a;
        wr_b    = acc_b && rwe_b && in_b;
        old_a   = in_a ? mem[addr_a] : '0;
        old_b   = in_b ? mem[addr_b] : '0;
        same    = acc_a && acc_b && (addr_a == addr_b);
        coll    = same && (rwe_a || rwe_b);
        both_wr = same && wr_a && wr_b;
        new_a   = DATA_W'(merge(MERGE_W'(old_a), MERGE_W'(data_a), MERGE_BE'(be_a)));
        // Port A owns every byte it enables; B layers its bytes on top of A's result
        be_b_eff = both_wr ? (be_b & ~be_a) : be_b;
        base_b   = both_wr ? new_a : old_b;
        new_b    = DATA_W'(merge(MERGE_W'(base_b), MERGE_W'(data_b), MERGE_BE'(be_b_eff)));
        pa_we    = clr_we || (wr_a && !both_wr);
        pa_addr  = clr_we ? clr_addr : addr_a;
        pa_data  = clr_we ? '0 : new_a;
    end

    always_ff @(posedge clk) begin
        if (pa_we) mem[pa_addr] <= pa_data;
        if (wr_b)  mem[addr_b]  <= new_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_outa <= '0;
            data_outb <= '0;
            valid_a   <= 1'b0;
            valid_b   <= 1'b0;
            collision <= 1'b0;
        end else begin
            valid_a   <= acc_a;
            valid_b   <= acc_b;
            collision <= coll;
            // A reading port always sees old data; only a writer honours RDW_MODE
            if (acc_a)
                data_outa <= (wr_a && RDW_MODE == RDW_WRITE_FIRST) ? (both_wr ? new_b : new_a) : old_a;
            if (acc_b)
                data_outb <= (wr_b && RDW_MODE == RDW_WRITE_FIRST) ? new_b : old_b;
        end
    end

endmodule
